// File: rtl/baud_pkg.sv
// Shared constants for the LC3 serial tick generators: clock rate, default
// oversampling ratio, counter width and the standard baud divisors.
package baud_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD_OSR   = 16;
  localparam int BAUD_CNT_W = 16;

  // Divisor giving baud*osr ticks per second, rounded to nearest.
  function automatic int baud_div(input int baud, input int osr);
    return (CLK_HZ + (baud * osr) / 2) / (baud * osr);
  endfunction

  localparam int DIV_9600         = baud_div(9600, BAUD_OSR);
  localparam int DIV_115200       = baud_div(115200, BAUD_OSR);
  localparam int BAUD_DEFAULT_DIV = DIV_9600;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic os;
    logic mid;
    logic bt;
  } tick_t;

endpackage

// File: rtl/baud_tick_chan.sv
// One tick channel: prescaler wrapping at the active divisor, oversample
// phase counter, shadowed divisor and registered single-cycle strobes.
module baud_tick_chan
  import baud_pkg::*;
#(
  parameter int CNT_W       = BAUD_CNT_W,
  parameter int OSR         = BAUD_OSR,
  parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic             tick_os_o,
  output logic             tick_mid_o,
  output logic             tick_o
);

  localparam int OC_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [OC_W-1:0]  OC_LAST = OC_W'(OSR - 1);
  localparam logic [OC_W-1:0]  OC_MID  = OC_W'(OSR / 2 - 1);

  logic [CNT_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] div_a_q, div_a_d;
  logic [CNT_W-1:0] div_s_q, div_s_d;
  logic [OC_W-1:0]  oc_q, oc_d;
  tick_t            tick_q, tick_d;

  logic [CNT_W-1:0] eff_div;
  logic [CNT_W-1:0] load_div;
  logic             wrap;

  assign eff_div  = (div_a_q == '0) ? CNT_W'(1) : div_a_q;
  assign wrap     = en_i && (pc_q == eff_div - CNT_W'(1));
  assign load_div = wr_en_i ? wdata_i : div_s_q;

  always_comb begin
    pc_d    = pc_q;
    oc_d    = oc_q;
    div_a_d = div_a_q;
    div_s_d = wr_en_i ? wdata_i : div_s_q;
    tick_d  = '0;
    if (restart_i) begin
      div_a_d = load_div;
      oc_d    = '0;
      // The restart cycle counts as phase 0, so the next os strobe lands D cycles later.
      pc_d    = (en_i && (load_div > CNT_W'(1))) ? CNT_W'(1) : '0;
    end else if (wrap) begin
      pc_d       = '0;
      div_a_d    = div_s_q;
      oc_d       = oc_q + OC_W'(1);
      tick_d.os  = 1'b1;
      tick_d.mid = (oc_q == OC_MID);
      tick_d.bt  = (oc_q == OC_LAST);
    end else if (en_i) begin
      pc_d = pc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      oc_q    <= '0;
      div_a_q <= RST_DIV;
      div_s_q <= RST_DIV;
      tick_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      oc_q    <= oc_d;
      div_a_q <= div_a_d;
      div_s_q <= div_s_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_os_o  = tick_q.os;
  assign tick_mid_o = tick_q.mid;
  assign tick_o     = tick_q.bt;

endmodule

// File: rtl/baud_tick_gen.sv
// Multi-channel baud/sample tick generator: one baud_tick_chan per channel,
// with the shared divisor write port decoded to a per-channel write enable.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = BAUD_CNT_W,
  parameter int OSR         = BAUD_OSR,
  parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH-1:0]          restart,
  input  logic                     div_we,
  input  logic [sel_w(N_CH)-1:0]   div_sel,
  input  logic [CNT_W-1:0]         div_wdata,
  output logic [N_CH-1:0]          tick_os,
  output logic [N_CH-1:0]          tick_mid,
  output logic [N_CH-1:0]          tick
);

  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH-1:0] wr_en;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      // Selects at or above N_CH match no channel and are dropped.
      assign wr_en[gi] = div_we && (div_sel == SEL_W'(gi));

      baud_tick_chan #(
        .CNT_W       (CNT_W),
        .OSR         (OSR),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en[gi]),
        .restart_i  (restart[gi]),
        .wr_en_i    (wr_en[gi]),
        .wdata_i    (div_wdata),
        .tick_os_o  (tick_os[gi]),
        .tick_mid_o (tick_mid[gi]),
        .tick_o     (tick[gi])
      );
    end
  endgenerate

endmodule
